// File: rtl/vector_mem_reader.sv
// Read-side DMA for the vector data memory. It walks a contiguous word range and
// serializes each word lane 0 first onto an 8-bit valid/ready byte stream.
module vector_mem_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int VECTOR_SIZE   = 6,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDRESS_WIDTH-1:0]          baseAddress,
  input  logic [ADDRESS_WIDTH:0]            wordCount,
  output logic                              busy,
  output logic                              done,
  output logic [ADDRESS_WIDTH-1:0]          memReadAddress,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] memReadData,
  output logic [DATA_WIDTH-1:0]             outData,
  output logic                              outValid,
  input  logic                              outReady,
  output logic [1:0]                        stateDebug
);

  localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);
  localparam logic [ADDRESS_WIDTH:0] ONE_WORD = (ADDRESS_WIDTH + 1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Stream handshake: a byte moves on a rising edge where outValid and outReady
  // are both high; outValid and outData hold steady until that edge.
  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]   rem_q, rem_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0]    word_q [VECTOR_SIZE];
  logic [DATA_WIDTH-1:0]    word_d [VECTOR_SIZE];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (wordCount != '0) begin
            addr_d  = baseAddress;
            rem_d   = wordCount;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        for (int i = 0; i < VECTOR_SIZE; i++) begin
          word_d[i] = memReadData[i*DATA_WIDTH +: DATA_WIDTH];
        end
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (outReady) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end else if (rem_q == ONE_WORD) begin
            state_d = S_DONE;
          end else begin
            // Address wraps naturally at the top of the address space.
            rem_d   = rem_q - 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  assign busy           = (state_q == S_FETCH) || (state_q == S_SEND);
  assign done           = (state_q == S_DONE);
  assign outValid       = (state_q == S_SEND);
  assign outData        = word_q[idx_q];
  assign memReadAddress = addr_q;
  assign stateDebug     = state_q;

endmodule

// File: doc/vector_mem_reader.md
Name: vector_mem_reader

Overview:
Read-side DMA for the CPU's vector data memory. The CPU pipeline only writes results into this memory; this block reads them back out. On a start command it walks a contiguous range of 48-bit memory words through a dedicated read port. Each word is serialized lane 0 first, as VECTOR_SIZE bytes, onto an 8-bit valid/ready output stream feeding the host/debug link.

Parameters:
DATA_WIDTH, 8, width of one vector lane and of the output stream
VECTOR_SIZE, 6, lanes per memory word; memory word width = DATA_WIDTH*VECTOR_SIZE
ADDRESS_WIDTH, 8, memory address width; address space = 2**ADDRESS_WIDTH words

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
start  input  1  one-cycle request to begin a transfer; sampled only in IDLE
baseAddress  input  ADDRESS_WIDTH  first word address, latched on accepted start
wordCount  input  ADDRESS_WIDTH+1  number of words to transfer, 0..2**ADDRESS_WIDTH, latched on accepted start
busy  output  1  high from the cycle after an accepted start until the DONE cycle
done  output  1  one-cycle pulse at transfer completion
memReadAddress  output  ADDRESS_WIDTH  read address to the memory's second read port; registered
memReadData  input  DATA_WIDTH*VECTOR_SIZE  memory word; combinational read of memReadAddress
outData  output  DATA_WIDTH  current byte, lane [idx] of the captured word
outValid  output  1  outData valid
outReady  input  1  sink accepts byte when outValid&outReady on a rising edge

Behaviour:
- Reset (reset=0, asynchronous) sets the state to IDLE and the following outputs to 0: busy, done, outValid, outData, memReadAddress. Lane index, remaining counter and word register are also cleared. Reset mid-transfer aborts the transfer with no done pulse; the first edge after release is in IDLE.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE: busy=0, outValid=0.
  - start=1 and wordCount!=0: latch memReadAddress<=baseAddress and remaining<=wordCount, go to FETCH.
  - start=1 and wordCount==0: go to DONE (done pulse, no bytes, no memory access).
- FETCH (1 cycle): busy=1, outValid=0. At the edge, capture memReadData into the word register, set idx<=0, go to SEND.
- SEND: busy=1, outValid=1, outData = word[idx*DATA_WIDTH +: DATA_WIDTH].
  - outData and outValid hold stable while outReady=0; outValid never drops until the handshake.
  - On handshake with idx<VECTOR_SIZE-1: idx<=idx+1.
  - On handshake with idx==VECTOR_SIZE-1 and remaining==1: go to DONE.
  - On handshake with idx==VECTOR_SIZE-1 otherwise: remaining<=remaining-1, memReadAddress<=memReadAddress+1 modulo 2**ADDRESS_WIDTH (wraps 255->0), go to FETCH.
- DONE (1 cycle): done=1, busy=0, outValid=0, then go to IDLE.
- start asserted in any state other than IDLE is ignored, not queued.
- Latency:
  - start accepted at edge N gives FETCH in cycle N+1 and first outValid in cycle N+2.
  - With outReady tied high, one word costs VECTOR_SIZE+1 cycles (7 at defaults).
  - A K-word transfer asserts done K*(VECTOR_SIZE+1)+1 cycles after the accepting edge.
- wordCount=2**ADDRESS_WIDTH (256) reads every address exactly once, wrapping back to baseAddress-1's successor chain, and terminates.
- Memory contents written by the CPU during a transfer are visible only if written before the corresponding FETCH cycle; no coherence is provided.

Test Plan:
1. Mem[0x10]=0x060504030201, outReady=1, start with base=0x10, count=1 -> bytes 01,02,03,04,05,06 on six consecutive cycles starting 2 cycles after start; done one cycle after the last byte; busy low again.
2. Backpressure: same word, outReady toggles 1,0,0,1,... -> byte order unchanged; outData/outValid stable while outReady=0; exactly 6 handshakes.
3. Wrap: base=0xFF, count=2, mem[0xFF]=A, mem[0x00]=B -> memReadAddress 0xFF then 0x00; 12 bytes A lanes 0..5 then B lanes 0..5; done at cycle 2*7+1 after start.
4. Zero count: start with count=0 -> done pulse the cycle after start; outValid never asserted; memReadAddress unchanged.
5. Start while busy: second start, base=0x40, mid-transfer -> ignored; byte stream and done timing identical to the run without it.
6. Reset mid-SEND: drive reset=0 between clock edges during byte 3 -> outValid, busy, done drop immediately; after release, a new start with count=1 transfers normally from its own base.
